// File: rtl/dvfs_seq_governor.sv
`timescale 1ns/1ps
// DVFS governor for one GPU clock domain: picks a performance level from activity,
// thermal warning and software cap, and sequences voltage/frequency steps via the PMIC.
module dvfs_seq_governor #(
   parameter int LVL_W       = 3,
   parameter int NUM_LVL     = 8,
   parameter int N_CH        = 4,
   parameter int ACT_MIN     = 2,
   parameter int CNT_W       = 16,
   parameter int UP_THRESH   = 1000,
   parameter int DOWN_THRESH = 4000,
   parameter int SETTLE_CYC  = 64,
   parameter int RESET_LVL   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  act,
   input  logic             temp_warn,
   input  logic [LVL_W-1:0] cap_level,
   input  logic             volt_ack,
   output logic [LVL_W-1:0] freq_level,
   output logic [LVL_W-1:0] volt_level,
   output logic [LVL_W-1:0] volt_target,
   output logic             volt_req,
   output logic             busy
);

   localparam int PC_W = $clog2(N_CH + 1);
   localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [LVL_W-1:0] MAX_LVL     = LVL_W'(NUM_LVL - 1);
   localparam logic [LVL_W-1:0] RST_LVL     = LVL_W'(RESET_LVL);
   localparam logic [CNT_W-1:0] UP_TH       = CNT_W'(UP_THRESH);
   localparam logic [CNT_W-1:0] DN_TH       = CNT_W'(DOWN_THRESH);
   localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_V_UP,
      ST_SETTLE,
      ST_SETTLE_DN,
      ST_V_DN
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [LVL_W-1:0] r_freq_level, w_freq_nxt;
   logic [LVL_W-1:0] r_volt_level, w_volt_nxt;
   logic [LVL_W-1:0] r_volt_target, w_tgt_nxt;
   logic             r_volt_req, w_req_nxt;
   logic [CNT_W-1:0] r_up_cnt, w_up_nxt;
   logic [CNT_W-1:0] r_dn_cnt, w_dn_nxt;
   logic [SC_W-1:0]  r_settle, w_settle_nxt;

   logic [PC_W-1:0]  w_popcnt;
   logic             w_high;
   logic [LVL_W-1:0] w_eff_cap;
   logic             w_ack;
   logic             w_lvl_pos;

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_popcnt = w_popcnt + PC_W'(act[i]);
      end
   end

   assign w_high    = (int'(w_popcnt) >= ACT_MIN);
   assign w_eff_cap = (cap_level > MAX_LVL) ? MAX_LVL : cap_level;
   assign w_ack     = volt_ack & r_volt_req;
   assign w_lvl_pos = (r_freq_level != '0);

   always_comb begin
      // NOTE: every next-value defaults to its current register first, so no path can infer a latch.
      w_state_nxt  = r_state;
      w_freq_nxt   = r_freq_level;
      w_volt_nxt   = r_volt_level;
      w_tgt_nxt    = r_volt_target;
      w_req_nxt    = r_volt_req;
      w_up_nxt     = r_up_cnt;
      w_dn_nxt     = r_dn_cnt;
      w_settle_nxt = r_settle;

      case (r_state)
         ST_IDLE: begin
            if (w_high && !temp_warn) begin
               w_dn_nxt = '0;
               if (r_up_cnt != '1) w_up_nxt = r_up_cnt + CNT_W'(1);
            end else begin
               w_up_nxt = '0;
               if (r_dn_cnt != '1) w_dn_nxt = r_dn_cnt + CNT_W'(1);
            end

            // Forced drops (cap, thermal) outrank the sustained-low drop, which outranks going up.
            if ((r_freq_level > w_eff_cap) || (temp_warn && w_lvl_pos) ||
                ((r_dn_cnt >= DN_TH) && w_lvl_pos)) begin
               w_freq_nxt   = r_freq_level - LVL_W'(1);
               w_settle_nxt = SETTLE_LOAD;
               w_up_nxt     = '0;
               w_dn_nxt     = '0;
               w_state_nxt  = ST_SETTLE_DN;
            end else if ((r_up_cnt >= UP_TH) && (r_freq_level < w_eff_cap) && !temp_warn) begin
               w_tgt_nxt   = r_freq_level + LVL_W'(1);
               w_req_nxt   = 1'b1;
               w_up_nxt    = '0;
               w_dn_nxt    = '0;
               w_state_nxt = ST_V_UP;
            end
         end

         ST_V_UP: begin
            if (w_ack) begin
               w_req_nxt    = 1'b0;
               w_volt_nxt   = r_volt_target;
               w_freq_nxt   = r_freq_level + LVL_W'(1);
               w_settle_nxt = SETTLE_LOAD;
               w_state_nxt  = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (r_settle == '0) w_state_nxt = ST_IDLE;
            else                w_settle_nxt = r_settle - SC_W'(1);
         end

         ST_SETTLE_DN: begin
            if (r_settle == '0) begin
               w_tgt_nxt   = r_freq_level;
               w_req_nxt   = 1'b1;
               w_state_nxt = ST_V_DN;
            end else begin
               w_settle_nxt = r_settle - SC_W'(1);
            end
         end

         ST_V_DN: begin
            if (w_ack) begin
               w_req_nxt   = 1'b0;
               w_volt_nxt  = r_volt_target;
               w_state_nxt = ST_IDLE;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_freq_level  <= RST_LVL;
         r_volt_level  <= RST_LVL;
         r_volt_target <= RST_LVL;
         r_volt_req    <= 1'b0;
         r_up_cnt      <= '0;
         r_dn_cnt      <= '0;
         r_settle      <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_freq_level  <= w_freq_nxt;
         r_volt_level  <= w_volt_nxt;
         r_volt_target <= w_tgt_nxt;
         r_volt_req    <= w_req_nxt;
         r_up_cnt      <= w_up_nxt;
         r_dn_cnt      <= w_dn_nxt;
         r_settle      <= w_settle_nxt;
      end
   end

   assign freq_level  = r_freq_level;
   assign volt_level  = r_volt_level;
   assign volt_target = r_volt_target;
   assign volt_req    = r_volt_req;
   assign busy        = (r_state != ST_IDLE);

   a_volt_covers_freq : assert property (@(posedge clk) disable iff (!rst_n)
      (r_volt_level >= r_freq_level) && ((r_volt_level - r_freq_level) <= LVL_W'(1)));

endmodule

// File: tb/tb_dvfs_seq_governor.sv
`timescale 1ns/1ps
// Directed bench for dvfs_seq_governor: timing sequences, a steady-state vector table,
// and a second instance with NUM_LVL=6 so software caps above the top level get clamped.
module tb_dvfs_seq_governor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] act = '0;
   logic       temp_warn = 1'b0;
   logic [2:0] cap_level = 3'd7;
   logic       volt_ack, volt_ack6;
   logic [2:0] freq_level, volt_level, volt_target;
   logic       volt_req, busy;
   logic [2:0] freq6, volt6, tgt6;
   logic       req6, busy6;
   bit         ack_en = 1'b1;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   dvfs_seq_governor #(
      .UP_THRESH(8), .DOWN_THRESH(16), .SETTLE_CYC(4)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .act(act), .temp_warn(temp_warn), .cap_level(cap_level),
      .volt_ack(volt_ack), .freq_level(freq_level), .volt_level(volt_level),
      .volt_target(volt_target), .volt_req(volt_req), .busy(busy)
   );

   dvfs_seq_governor #(
      .NUM_LVL(6), .UP_THRESH(8), .DOWN_THRESH(16), .SETTLE_CYC(4)
   ) u_dut6 (
      .clk(clk), .rst_n(rst_n), .act(act), .temp_warn(temp_warn), .cap_level(cap_level),
      .volt_ack(volt_ack6), .freq_level(freq6), .volt_level(volt6),
      .volt_target(tgt6), .volt_req(req6), .busy(busy6)
   );

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick(input int cyc);
      repeat (cyc) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      act       = '0;
      temp_warn = 1'b0;
      cap_level = 3'd7;
      ack_en    = 1'b1;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_freq(input string name, input int lvl, input int max_cyc, output int cyc);
      cyc = 0;
      while (int'(freq_level) != lvl && cyc < max_cyc) begin
         tick(1);
         cyc++;
      end
      check(name, int'(freq_level), lvl);
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int cyc = 0;
      while (busy && cyc < max_cyc) begin
         tick(1);
         cyc++;
      end
      check(name, int'(busy), 0);
   endtask

   task automatic wait_req(input string name, input int max_cyc);
      int cyc = 0;
      while (!volt_req && cyc < max_cyc) begin
         tick(1);
         cyc++;
      end
      check(name, int'(volt_req), 1);
   endtask

   // Regulator model: acknowledges on the third sampled cycle of a pending request.
   initial begin
      int age;
      age = 0;
      volt_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (volt_req && ack_en) begin
            age++;
            volt_ack = (age >= 3);
         end else begin
            age = 0;
            volt_ack = 1'b0;
         end
      end
   end

   initial begin
      int age;
      age = 0;
      volt_ack6 = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (req6 && ack_en) begin
            age++;
            volt_ack6 = (age >= 3);
         end else begin
            age = 0;
            volt_ack6 = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("inv_volt_freq", int'(volt_level >= freq_level && (volt_level - freq_level) <= 3'd1), 1);
            check("inv_volt_freq6", int'(volt6 >= freq6 && (volt6 - freq6) <= 3'd1), 1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef struct {
      logic [3:0] act;
      logic       temp;
      logic [2:0] cap;
      int         cyc;
      logic [2:0] e_freq;
      logic [2:0] e_volt;
      logic [2:0] e_freq6;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int offset, seen, rises, steps, wrong_dir, prev;

      tbl[0] = '{4'b1111, 1'b0, 3'd7, 100, 3'd7, 3'd7, 3'd5};
      tbl[1] = '{4'b0001, 1'b0, 3'd7,  60, 3'd5, 3'd5, 3'd3};
      tbl[2] = '{4'b0110, 1'b0, 3'd4,  40, 3'd4, 3'd4, 3'd4};
      tbl[3] = '{4'b0011, 1'b1, 3'd7,  36, 3'd0, 3'd0, 3'd0};
      tbl[4] = '{4'b1100, 1'b0, 3'd7,  40, 3'd2, 3'd2, 3'd2};
      tbl[5] = '{4'b0000, 1'b0, 3'd0,  30, 3'd0, 3'd0, 3'd0};

      // Reset values and exact up-step timing.
      tick(2);
      check("rst_freq", int'(freq_level), 2);
      check("rst_volt", int'(volt_level), 2);
      check("rst_tgt", int'(volt_target), 2);
      check("rst_req", int'(volt_req), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick(1);
      act = 4'b0011;
      tick(8);
      check("up_req_early", int'(volt_req), 0);
      tick(1);
      check("up_req_rise", int'(volt_req), 1);
      check("up_tgt", int'(volt_target), 3);
      check("up_busy", int'(busy), 1);
      check("up_freq_hold", int'(freq_level), 2);
      check("up_volt_hold", int'(volt_level), 2);
      tick(2);
      check("up_freq_preack", int'(freq_level), 2);
      tick(1);
      check("up_freq", int'(freq_level), 3);
      check("up_volt", int'(volt_level), 3);
      check("up_req_fall", int'(volt_req), 0);
      tick(3);
      check("settle_busy", int'(busy), 1);
      tick(1);
      check("settle_done", int'(busy), 0);
      offset = 4;
      for (int l = 4; l <= 7; l++) begin
         wait_freq("up_ramp", l, 40, n);
         check("up_spacing", n + offset, 16);
         offset = 0;
      end
      seen = 0;
      repeat (60) begin
         tick(1);
         if (volt_req) seen++;
      end
      check("top_no_req", seen, 0);
      check("top_volt", int'(volt_level), 7);
      check("clamp6_freq", int'(freq6), 5);
      check("clamp6_volt", int'(volt6), 5);

      // Down step: frequency first, voltage after settling.
      do_reset();
      tick(16);
      check("dn_freq_early", int'(freq_level), 2);
      tick(1);
      check("dn_freq", int'(freq_level), 1);
      check("dn_volt_hold", int'(volt_level), 2);
      check("dn_busy", int'(busy), 1);
      check("dn_req_first", int'(volt_req), 0);
      tick(3);
      check("dn_req_early", int'(volt_req), 0);
      tick(1);
      check("dn_req", int'(volt_req), 1);
      check("dn_tgt", int'(volt_target), 1);
      tick(3);
      check("dn_volt", int'(volt_level), 1);
      check("dn_idle", int'(busy), 0);
      wait_freq("dn2_freq", 0, 40, n);
      check("dn2_spacing", n, 17);
      wait_idle("dn2_idle", 20);
      check("dn2_volt", int'(volt_level), 0);
      seen = 0;
      repeat (40) begin
         tick(1);
         if (volt_req) seen++;
      end
      check("floor_no_req", seen, 0);

      // Thermal pulse at level 5, then held thermal warning.
      do_reset();
      act = 4'b0011;
      wait_freq("temp_reach5", 5, 80, n);
      wait_idle("temp_idle5", 20);
      temp_warn = 1'b1;
      tick(1);
      temp_warn = 1'b0;
      check("temp_freq", int'(freq_level), 4);
      check("temp_volt", int'(volt_level), 5);
      check("temp_req", int'(volt_req), 0);
      wait_idle("temp_idle4", 20);
      check("temp_volt4", int'(volt_level), 4);
      temp_warn = 1'b1;
      rises = 0;
      prev = int'(freq_level);
      repeat (80) begin
         tick(1);
         if (int'(freq_level) > prev) rises++;
         prev = int'(freq_level);
      end
      check("temp_no_up", rises, 0);
      check("temp_floor", int'(freq_level), 0);
      check("temp_floor_volt", int'(volt_level), 0);
      temp_warn = 1'b0;

      // Software cap below the current level, then raised again.
      do_reset();
      act = 4'b0011;
      wait_freq("cap_reach6", 6, 100, n);
      wait_idle("cap_idle6", 20);
      cap_level = 3'd3;
      steps = 0;
      wrong_dir = 0;
      prev = int'(freq_level);
      repeat (60) begin
         tick(1);
         if (int'(freq_level) != prev) begin
            if (int'(freq_level) == prev - 1) steps++;
            else wrong_dir++;
         end
         prev = int'(freq_level);
      end
      check("cap_steps", steps, 3);
      check("cap_dir", wrong_dir, 0);
      check("cap_freq", int'(freq_level), 3);
      check("cap_volt", int'(volt_level), 3);
      check("cap_busy", int'(busy), 0);
      cap_level = 3'd7;
      wait_freq("cap_resume", 4, 40, n);
      wait_freq("cap_resume6", 5, 40, n);
      check("cap_resume6_freq", int'(freq6), 5);

      // Steady-state vectors applied back to back from reset.
      do_reset();
      foreach (tbl[i]) begin
         act       = tbl[i].act;
         temp_warn = tbl[i].temp;
         cap_level = tbl[i].cap;
         tick(tbl[i].cyc);
         check($sformatf("vec%0d_freq", i), int'(freq_level), int'(tbl[i].e_freq));
         check($sformatf("vec%0d_volt", i), int'(volt_level), int'(tbl[i].e_volt));
         check($sformatf("vec%0d_busy", i), int'(busy), 0);
         check($sformatf("vec%0d_freq6", i), int'(freq6), int'(tbl[i].e_freq6));
      end

      // Asynchronous reset while a voltage request is outstanding.
      do_reset();
      act = 4'b0011;
      wait_req("vup_req", 30);
      check("vup_tgt", int'(volt_target), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_req", int'(volt_req), 0);
      check("areset_tgt", int'(volt_target), 2);
      check("areset_freq", int'(freq_level), 2);
      check("areset_volt", int'(volt_level), 2);
      check("areset_busy", int'(busy), 0);

      // Regulator stalls for 100 cycles in V_UP.
      ack_en = 1'b0;
      rst_n = 1'b1;
      wait_req("stall_req", 30);
      tick(100);
      check("stall_freq", int'(freq_level), 2);
      check("stall_volt", int'(volt_level), 2);
      check("stall_req_held", int'(volt_req), 1);
      check("stall_tgt", int'(volt_target), 3);
      check("stall_busy", int'(busy), 1);
      ack_en = 1'b1;
      wait_freq("stall_release", 3, 10, n);
      act = 4'b0001;
      wait_freq("single_bit_low", 2, 60, n);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
